scaler_vertical_scheduler: RTL and testbench

Vertical-scaling sequencer for the scaler matrix line-buffer reader. It connects to the reader's connect/stride/repeat/read/done interface and, for every output row, selects the source row by a Q16.16 phase accumulator. For each connect it either strides (discards a source line), streams one output row of window reads, or repeats the current window. Read issue is throttled by a credit counter returned by the downstream filter.

---
 rtl/scaler_pkg.sv | 29 ++
 rtl/scaler_credit_counter.sv | 35 +++
 rtl/scaler_vertical_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_scaler_vertical_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scaler_pkg.sv
// scaler_pkg: shared state encoding, Q16.16 constants and helpers for the
// scaler line-buffer sequencing blocks.
package scaler_pkg;

    localparam int unsigned FRAC_BITS = 16;
    localparam logic [31:0] ONE       = 32'h0001_0000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_STREAM = 3'd2,
        ST_DONE   = 3'd3,
        ST_NEXT   = 3'd4
    } sched_state_e;

    // Ceiling log2, with CLOG2(0) = CLOG2(1) = 0.
    function automatic int unsigned CLOG2(input int unsigned value);
        int unsigned res;
        int unsigned v;
        res = 0;
        v   = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/scaler_credit_counter.sv
// scaler_credit_counter: saturating up/down credit counter for downstream slots.
// Ports: core_clk/core_rst_n, load (refill to CREDIT_MAX), dec (one slot used,
// only asserted while credit_ok), inc (one slot returned), credit_ok (credit != 0).
module scaler_credit_counter #(
    parameter int unsigned CREDIT_MAX      = 16,
    parameter int unsigned CREDIT_BITWIDTH = 5
) (
    input  logic core_clk,
    input  logic core_rst_n,
    input  logic load,
    input  logic dec,
    input  logic inc,
    output logic credit_ok
);

    localparam logic [CREDIT_BITWIDTH-1:0] MAX_VAL = CREDIT_BITWIDTH'(CREDIT_MAX);

    logic [CREDIT_BITWIDTH-1:0] credit;

    // A read and a return in the same cycle cancel; returns at full are dropped.
    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            credit <= MAX_VAL;
        end else if (load) begin
            credit <= MAX_VAL;
        end else if (dec && !inc) begin
            credit <= credit - CREDIT_BITWIDTH'(1);
        end else if (inc && !dec && (credit != MAX_VAL)) begin
            credit <= credit + CREDIT_BITWIDTH'(1);
        end
    end

    assign credit_ok = (credit != '0);

endmodule

// File: rtl/scaler_vertical_scheduler.sv
// scaler_vertical_scheduler: per output row, picks the source row from a Q16.16
// phase accumulator and tells the line-buffer reader to stride, stream a row of
// window reads, or repeat the current window. Reads are throttled by credits.
// Ports: core_clk/core_rst_n; core_start + cfg_* (frame setup); reader side
// s_axis_connect_valid/ready, matrix_ram_read_stride/repeat/en/done;
// credit_return from the downstream filter; busy and frame_done status.
module scaler_vertical_scheduler
    import scaler_pkg::*;
#(
    parameter int unsigned DST_W_BITWIDTH  = 12,
    parameter int unsigned ROW_BITWIDTH    = 12,
    parameter int unsigned CREDIT_MAX      = 16,
    parameter int unsigned CREDIT_BITWIDTH = 5
) (
    input  logic                      core_clk,
    input  logic                      core_rst_n,
    input  logic                      core_start,
    input  logic [ROW_BITWIDTH-1:0]   cfg_src_height,
    input  logic [ROW_BITWIDTH-1:0]   cfg_dst_height,
    input  logic [DST_W_BITWIDTH-1:0] cfg_dst_width,
    input  logic [31:0]               cfg_step,
    input  logic [31:0]               cfg_phase_init,
    input  logic                      s_axis_connect_valid,
    output logic                      s_axis_connect_ready,
    output logic                      matrix_ram_read_stride,
    output logic                      matrix_ram_read_repeat,
    output logic                      matrix_ram_read_en,
    output logic                      matrix_ram_read_done,
    input  logic                      credit_return,
    output logic                      busy,
    output logic                      frame_done
);

    localparam int unsigned ROW_W1 = ROW_BITWIDTH + 1;

    sched_state_e              state;
    logic [ROW_BITWIDTH-1:0]   src_h_q;
    logic [ROW_BITWIDTH-1:0]   dst_h_q;
    logic [DST_W_BITWIDTH-1:0] dst_w_q;
    logic [31:0]               step_q;
    logic [31:0]               acc;
    logic [ROW_BITWIDTH-1:0]   target_q;
    logic [ROW_BITWIDTH-1:0]   cur_row;
    logic [ROW_BITWIDTH-1:0]   out_row;
    logic [DST_W_BITWIDTH-1:0] pix_cnt;

    logic                      credit_ok;
    logic                      start_c;
    logic                      handshake_c;
    logic                      read_c;
    logic [31:0]               acc_next;
    logic [ROW_BITWIDTH-1:0]   next_target;
    logic [ROW_W1-1:0]         row_after;

    // Integer part of the phase, clamped to the last source row.
    function automatic logic [ROW_BITWIDTH-1:0] clamp_row(
        input logic [15:0]             ip,
        input logic [ROW_BITWIDTH-1:0] src_h
    );
        logic [ROW_BITWIDTH-1:0] last;
        last = src_h - ROW_BITWIDTH'(1);
        if (32'(ip) > 32'(last)) begin
            return last;
        end
        return ROW_BITWIDTH'(ip);
    endfunction

    assign start_c     = (state == ST_IDLE) && core_start;
    assign handshake_c = s_axis_connect_ready && s_axis_connect_valid;
    assign read_c      = (state == ST_STREAM) && credit_ok;
    assign acc_next    = acc + step_q;
    assign next_target = clamp_row(acc_next[31:FRAC_BITS], src_h_q);
    assign row_after   = {1'b0, out_row} + ROW_W1'(1);

    // Stride decision seen by the reader at the connect handshake.
    assign matrix_ram_read_stride = (target_q > cur_row);
    assign matrix_ram_read_en     = read_c;

    scaler_credit_counter #(
        .CREDIT_MAX      (CREDIT_MAX),
        .CREDIT_BITWIDTH (CREDIT_BITWIDTH)
    ) u_credit (
        .core_clk   (core_clk),
        .core_rst_n (core_rst_n),
        .load       (start_c),
        .dec        (read_c),
        .inc        (credit_return),
        .credit_ok  (credit_ok)
    );

    // Row sequencer: connect decision, row streaming, phase advance.
    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            state                  <= ST_IDLE;
            src_h_q                <= '0;
            dst_h_q                <= '0;
            dst_w_q                <= '0;
            step_q                 <= '0;
            acc                    <= '0;
            target_q               <= '0;
            cur_row                <= '0;
            out_row                <= '0;
            pix_cnt                <= '0;
            s_axis_connect_ready   <= 1'b0;
            matrix_ram_read_repeat <= 1'b0;
            matrix_ram_read_done   <= 1'b0;
            busy                   <= 1'b0;
            frame_done             <= 1'b0;
        end else begin
            matrix_ram_read_done <= 1'b0;
            frame_done           <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (core_start) begin
                        src_h_q  <= cfg_src_height;
                        dst_h_q  <= cfg_dst_height;
                        dst_w_q  <= cfg_dst_width;
                        step_q   <= cfg_step;
                        acc      <= cfg_phase_init;
                        target_q <= clamp_row(cfg_phase_init[31:FRAC_BITS], cfg_src_height);
                        cur_row  <= '0;
                        out_row  <= '0;
                        if ((cfg_dst_height == '0) || (cfg_dst_width == '0)) begin
                            frame_done <= 1'b1;
                        end else begin
                            state                <= ST_ARM;
                            s_axis_connect_ready <= 1'b1;
                            busy                 <= 1'b1;
                        end
                    end
                end
                ST_ARM: begin
                    if (handshake_c) begin
                        if (matrix_ram_read_stride) begin
                            cur_row <= cur_row + ROW_BITWIDTH'(1);
                        end else begin
                            state                <= ST_STREAM;
                            s_axis_connect_ready <= 1'b0;
                            pix_cnt              <= dst_w_q;
                        end
                    end
                end
                ST_STREAM: begin
                    if (read_c) begin
                        pix_cnt <= pix_cnt - DST_W_BITWIDTH'(1);
                        if (pix_cnt == DST_W_BITWIDTH'(1)) begin
                            state                  <= ST_DONE;
                            matrix_ram_read_done   <= 1'b1;
                            // Decided early so it holds through DONE and NEXT.
                            matrix_ram_read_repeat <= (row_after < {1'b0, dst_h_q}) &&
                                                      (next_target == cur_row);
                        end
                    end
                end
                ST_DONE: begin
                    acc      <= acc_next;
                    target_q <= next_target;
                    out_row  <= out_row + ROW_BITWIDTH'(1);
                    state    <= ST_NEXT;
                end
                ST_NEXT: begin
                    matrix_ram_read_repeat <= 1'b0;
                    if (out_row >= dst_h_q) begin
                        state      <= ST_IDLE;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end else begin
                        state                <= ST_ARM;
                        s_axis_connect_ready <= 1'b1;
                        if (!matrix_ram_read_repeat) begin
                            cur_row <= cur_row + ROW_BITWIDTH'(1);
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scaler_vertical_scheduler.sv
// Scoreboard bench: an abstract model of the frame (target row per output row,
// stride/stream/repeat decisions) fills a queue of expected reader events; a
// negedge monitor pops and compares whenever the DUT shows an event.
module tb_scaler_vertical_scheduler;
    import scaler_pkg::*;

    localparam int CMAX = 2;
    localparam int EV_STREAM = 0;
    localparam int EV_STRIDE = 1;
    localparam int EV_REP0   = 2;
    localparam int EV_REP1   = 3;
    localparam int EV_FRAME  = 4;
    localparam int FRAME_LIMIT = 5000;

    logic        core_clk;
    logic        core_rst_n;
    logic        core_start;
    logic [11:0] cfg_src_height;
    logic [11:0] cfg_dst_height;
    logic [11:0] cfg_dst_width;
    logic [31:0] cfg_step;
    logic [31:0] cfg_phase_init;
    logic        s_axis_connect_valid;
    logic        s_axis_connect_ready;
    logic        matrix_ram_read_stride;
    logic        matrix_ram_read_repeat;
    logic        matrix_ram_read_en;
    logic        matrix_ram_read_done;
    logic        credit_return;
    logic        busy;
    logic        frame_done;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int held = 0;
    int rd_cnt = 0;
    int frame_reads = 0;
    int done_cnt = 0;
    int done_base = 0;
    int cur_w = 0;
    int rep_pending = 0;
    int rep_exp = 0;
    int prev_rd = 0;
    bit vld_rand = 1'b0;
    bit ret_en = 1'b0;

    scaler_vertical_scheduler #(
        .DST_W_BITWIDTH  (12),
        .ROW_BITWIDTH    (12),
        .CREDIT_MAX      (CMAX),
        .CREDIT_BITWIDTH (2)
    ) dut (
        .core_clk               (core_clk),
        .core_rst_n             (core_rst_n),
        .core_start             (core_start),
        .cfg_src_height         (cfg_src_height),
        .cfg_dst_height         (cfg_dst_height),
        .cfg_dst_width          (cfg_dst_width),
        .cfg_step               (cfg_step),
        .cfg_phase_init         (cfg_phase_init),
        .s_axis_connect_valid   (s_axis_connect_valid),
        .s_axis_connect_ready   (s_axis_connect_ready),
        .matrix_ram_read_stride (matrix_ram_read_stride),
        .matrix_ram_read_repeat (matrix_ram_read_repeat),
        .matrix_ram_read_en     (matrix_ram_read_en),
        .matrix_ram_read_done   (matrix_ram_read_done),
        .credit_return          (credit_return),
        .busy                   (busy),
        .frame_done             (frame_done)
    );

    initial begin
        core_clk = 1'b0;
        forever #5 core_clk = ~core_clk;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pop_exp();
        if (exp_q.size() == 0) return -1;
        return exp_q.pop_front();
    endfunction

    // Source row selected for output row r.
    function automatic int tgt(input int src, input logic [31:0] step,
                               input logic [31:0] phase, input int r);
        logic [31:0] a;
        int ip;
        a  = phase + step * 32'(r);
        ip = int'(a[31:16]);
        return (ip > src - 1) ? src - 1 : ip;
    endfunction

    // Expected reader-visible event sequence of one frame.
    task automatic push_model(input int src, input int dst, input int w,
                              input logic [31:0] step, input logic [31:0] phase);
        int cur;
        bit rep;
        cur = 0;
        if (dst != 0 && w != 0) begin
            for (int r = 0; r < dst; r++) begin
                while (tgt(src, step, phase, r) > cur) begin
                    exp_q.push_back(EV_STRIDE);
                    cur++;
                end
                exp_q.push_back(EV_STREAM);
                rep = (r + 1 < dst) && (tgt(src, step, phase, r + 1) == cur);
                exp_q.push_back(rep ? EV_REP1 : EV_REP0);
                if (!rep) cur++;
            end
        end
        exp_q.push_back(EV_FRAME);
    endtask

    // Reader: requests connects.
    initial begin
        s_axis_connect_valid = 1'b0;
        forever begin
            @(posedge core_clk);
            #1;
            s_axis_connect_valid = vld_rand ? ($urandom % 4 != 0) : 1'b1;
        end
    end

    // Downstream filter: frees held slots at random, occasionally a spurious return.
    initial begin
        credit_return = 1'b0;
        forever begin
            @(posedge core_clk);
            #1;
            if (!ret_en)        credit_return = 1'b0;
            else if (held > 0)  credit_return = ($urandom % 3 != 0);
            else                credit_return = ($urandom % 6 == 0);
        end
    end

    // Monitor / scoreboard.
    initial begin
        int e;
        forever begin
            @(negedge core_clk);
            if (!core_rst_n) begin
                exp_q.delete();
                held = 0; rd_cnt = 0; rep_pending = 0; prev_rd = 0;
            end else if (core_start && !busy) begin
                held = 0; rd_cnt = 0; frame_reads = 0; prev_rd = 0;
            end else begin
                if (rep_pending != 0) begin
                    check("repeat_next", int'(matrix_ram_read_repeat), rep_exp);
                    rep_pending = 0;
                end
                if (s_axis_connect_valid && s_axis_connect_ready) begin
                    e = pop_exp();
                    check("connect_stride", matrix_ram_read_stride ? EV_STRIDE : EV_STREAM, e);
                end
                if (matrix_ram_read_en) begin
                    check("credit_available", int'(held < CMAX), 1);
                    rd_cnt++;
                    frame_reads++;
                end
                held = held + int'(matrix_ram_read_en) - int'(credit_return);
                if (held < 0) held = 0;
                if (matrix_ram_read_done) begin
                    check("done_after_last_read", prev_rd, 1);
                    check("row_reads", rd_cnt, cur_w);
                    rd_cnt = 0;
                    e = pop_exp();
                    rep_exp = (e == EV_REP1) ? 1 : ((e == EV_REP0) ? 0 : -1);
                    check("repeat_at_done", int'(matrix_ram_read_repeat), rep_exp);
                    rep_pending = 1;
                end
                if (frame_done) begin
                    e = pop_exp();
                    check("frame_done_event", EV_FRAME, e);
                    check("busy_at_frame_done", int'(busy), 0);
                    done_cnt++;
                end
                prev_rd = int'(matrix_ram_read_en);
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"},      int'(s_axis_connect_ready), 0);
        check({tag, "_stride"},     int'(matrix_ram_read_stride), 0);
        check({tag, "_repeat"},     int'(matrix_ram_read_repeat), 0);
        check({tag, "_read_en"},    int'(matrix_ram_read_en), 0);
        check({tag, "_read_done"},  int'(matrix_ram_read_done), 0);
        check({tag, "_busy"},       int'(busy), 0);
        check({tag, "_frame_done"}, int'(frame_done), 0);
    endtask

    task automatic start_frame(input int src, input int dst, input int w,
                               input logic [31:0] step, input logic [31:0] phase);
        cfg_src_height = 12'(src);
        cfg_dst_height = 12'(dst);
        cfg_dst_width  = 12'(w);
        cfg_step       = step;
        cfg_phase_init = phase;
        cur_w          = w;
        done_base      = done_cnt;
        push_model(src, dst, w, step, phase);
        @(posedge core_clk);
        #1 core_start = 1'b1;
        @(posedge core_clk);
        #1 core_start = 1'b0;
        if (dst == 0 || w == 0) begin
            check("zero_size_frame_done", int'(frame_done), 1);
            check("zero_size_busy", int'(busy), 0);
            check("zero_size_ready", int'(s_axis_connect_ready), 0);
        end
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        while (done_cnt == done_base && n < FRAME_LIMIT) begin
            @(posedge core_clk);
            n++;
        end
        #1;
        check("frame_completed_in_time", int'(done_cnt > done_base), 1);
        if (done_cnt == done_base) begin
            core_rst_n = 1'b0;
            repeat (2) @(posedge core_clk);
            #3 core_rst_n = 1'b1;
        end
        repeat (2) @(posedge core_clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic run_frame(input int src, input int dst, input int w,
                             input logic [31:0] step, input logic [31:0] phase);
        start_frame(src, dst, w, step, phase);
        wait_frame();
    endtask

    initial begin
        int n;
        core_rst_n     = 1'b0;
        core_start     = 1'b0;
        cfg_src_height = '0;
        cfg_dst_height = '0;
        cfg_dst_width  = '0;
        cfg_step       = '0;
        cfg_phase_init = '0;
        #12 check_idle_outputs("reset");
        #11 core_rst_n = 1'b1;

        vld_rand = 1'b1;
        ret_en   = 1'b1;
        run_frame(4, 8, 3, 32'h0000_8000, 32'h0);      // upscale 2x
        run_frame(8, 4, 3, 32'h0002_0000, 32'h0);      // downscale 2x
        run_frame(2, 3, 4, ONE, 32'h0001_8000);        // clamped targets
        run_frame(4, 4, 0, ONE, 32'h0);                // zero width
        run_frame(4, 0, 3, ONE, 32'h0);                // zero height

        // Credit throttle: no returns, so reads stop at the credit limit.
        vld_rand = 1'b0;
        ret_en   = 1'b0;
        start_frame(1, 1, 5, ONE, 32'h0);
        repeat (10) @(posedge core_clk);
        #1 check("throttle_reads", frame_reads, CMAX);
        ret_en = 1'b1;
        wait_frame();
        check("throttle_total_reads", frame_reads, 5);

        // Asynchronous reset in the middle of a row.
        start_frame(3, 2, 5, ONE, 32'h0);
        n = 0;
        do begin
            @(negedge core_clk);
            #1;
            n++;
        end while (frame_reads < 2 && n < 200);
        check("reads_before_reset", int'(frame_reads >= 2), 1);
        core_rst_n = 1'b0;
        #1 check_idle_outputs("async_reset");
        repeat (2) @(posedge core_clk);
        #3 core_rst_n = 1'b1;
        run_frame(3, 2, 5, ONE, 32'h0);

        // Randomized frames.
        vld_rand = 1'b1;
        for (int i = 0; i < 25; i++) begin
            run_frame($urandom_range(1, 12), $urandom_range(1, 12), $urandom_range(1, 6),
                      32'($urandom_range(32'h2000, 32'h30000)),
                      32'($urandom_range(0, 32'h28000)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
